regfile_vec_mp: RTL

// - Parametrised successor of the vector register file in the decode/register-read stage: NUM_VREGS vectors of NUM_LANES x LANE_W bits.
// - Two combinational read ports, one write port with per-lane write mask, and a mapped window of snapshot-able performance counters.
// - Sequential bulk-clear engine zeroes the file one register per cycle without a global reset.

---
 rtl/regfile_vec_mp.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/regfile_vec_mp.sv
// Vector register file with two combinational read ports, a lane-masked write port,
// snapshot perf-counter window and a one-register-per-cycle bulk-clear engine.
// Optional same-cycle write-to-read bypass: define REGFILE_VEC_BYPASS_EN.
module regfile_vec_mp #(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned LANE_W    = 16,
  parameter int unsigned NUM_VREGS = 8,
  parameter int unsigned VREG_BASE = 16,
  parameter int unsigned NUM_PERF  = 4,
  parameter int unsigned PERF_BASE = 24,
  localparam int unsigned VW        = NUM_LANES * LANE_W,
  // Keep one (unused) shadow slot when no perf window is configured so widths stay legal
  localparam int unsigned PerfSlots = (NUM_PERF == 0) ? 1 : NUM_PERF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              vra1,
  input  logic [4:0]              vra2,
  output logic [VW-1:0]           vrd1,
  output logic [VW-1:0]           vrd2,
  input  logic                    vwe3,
  input  logic [4:0]              vwa3,
  input  logic [VW-1:0]           vwd3,
  input  logic [NUM_LANES-1:0]    vwmask3,
  input  logic [PerfSlots*VW-1:0] perf_in,
  input  logic                    perf_snap,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic                    wr_drop
);

  localparam int unsigned IdxW     = (NUM_VREGS > 1) ? $clog2(NUM_VREGS) : 1;
  localparam int unsigned PerfIdxW = (PerfSlots > 1) ? $clog2(PerfSlots) : 1;

  typedef logic [NUM_VREGS-1:0][VW-1:0] vrf_t;
  typedef logic [PerfSlots-1:0][VW-1:0] perf_t;
  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   clr_idx_q, clr_idx_d;
  vrf_t              vrf_q, vrf_d;
  perf_t             perf_q;
  logic              wr_drop_q, wr_drop_d;
  logic              wr_accept;
  logic [IdxW-1:0]   wr_idx;
  logic [VW-1:0]     wr_word;

  function automatic logic in_vreg(input logic [4:0] a);
    return (32'(a) >= VREG_BASE) && (32'(a) < VREG_BASE + NUM_VREGS);
  endfunction

  function automatic logic in_perf(input logic [4:0] a);
    return (32'(a) >= PERF_BASE) && (32'(a) < PERF_BASE + NUM_PERF);
  endfunction

  function automatic logic [VW-1:0] merge_lanes(input logic [VW-1:0]        old_w,
                                                input logic [VW-1:0]        new_w,
                                                input logic [NUM_LANES-1:0] mask);
    logic [VW-1:0] res;
    res = old_w;
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      if (mask[l]) res[l*LANE_W +: LANE_W] = new_w[l*LANE_W +: LANE_W];
    end
    return res;
  endfunction

  function automatic logic [VW-1:0] read_word(input logic [4:0] a, input vrf_t vrf,
                                              input perf_t perf);
    logic [VW-1:0] res;
    res = '0;
    if (in_vreg(a)) begin
      res = vrf[IdxW'(32'(a) - VREG_BASE)];
    end else if (in_perf(a)) begin
      res = perf[PerfIdxW'(32'(a) - PERF_BASE)];
    end
    return res;
  endfunction

  // A clear request wins over a same-edge write, so the write is dropped.
  always_comb begin
    wr_accept = vwe3 && in_vreg(vwa3) && (state_q == StIdle) && !clr_req;
    wr_drop_d = vwe3 && !wr_accept;
    wr_idx    = IdxW'(32'(vwa3) - VREG_BASE);
    wr_word   = merge_lanes(vrf_q[wr_idx], vwd3, vwmask3);
  end

  always_comb begin
    vrf_d = vrf_q;
    if (state_q == StClear) vrf_d[clr_idx_q] = '0;
    if (wr_accept) vrf_d[wr_idx] = wr_word;
  end

  always_comb begin
    vrd1 = read_word(vra1, vrf_q, perf_q);
    vrd2 = read_word(vra2, vrf_q, perf_q);
`ifdef REGFILE_VEC_BYPASS_EN
    if (wr_accept && (vra1 == vwa3)) vrd1 = wr_word;
    if (wr_accept && (vra2 == vwa3)) vrd2 = wr_word;
`endif
  end

  // FSM: state register
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      StClear: begin
        if (clr_idx_q == IdxW'(NUM_VREGS - 1)) begin
          state_d   = StDone;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    clr_busy = 1'b0;
    clr_done = 1'b0;
    unique case (state_q)
      StClear: clr_busy = 1'b1;
      StDone:  clr_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      vrf_q     <= '0;
      perf_q    <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      vrf_q     <= vrf_d;
      wr_drop_q <= wr_drop_d;
      if (perf_snap) perf_q <= perf_in;
    end
  end

  assign wr_drop = wr_drop_q;

endmodule
